// File: rtl/hpdl_write_sequencer_pkg.sv
// Shared types and constants for the HPDL-1414 write sequencer.
package hpdl_pkg;

  typedef enum logic [2:0] {
    ST_GAP,
    ST_FETCH,
    ST_LATCH,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_e;

  localparam logic [6:0] CH_SPACE   = 7'h20;
  localparam logic [6:0] CH_CARET   = 7'h5F;
  localparam int         NUM_PLACES = 16;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hpdl_write_sequencer_char_map.sv
// Combinational byte-to-display-code map: printable range passes, lowercase folds to
// uppercase, everything else becomes a space; the caret overrides all of it.
module hpdl_char_map
  import hpdl_pkg::*;
(
  input  logic [7:0] i_char,
  input  logic       i_caret,
  output logic [6:0] o_char
);

  // Bits [7:5] identify the 32-code band: 001/010 printable, 011 lowercase.
  always_comb begin
    o_char = CH_SPACE;
    if (i_caret) begin
      o_char = CH_CARET;
    end else begin
      case (i_char[7:5])
        3'b001, 3'b010: o_char = i_char[6:0];
        3'b011:         o_char = {2'b10, i_char[4:0]};
        default:        o_char = CH_SPACE;
      endcase
    end
  end

endmodule

// File: rtl/hpdl_write_sequencer.sv
// Scans a 16-entry character buffer and drives four HPDL-1414 displays with full
// setup/strobe/hold write cycles, all on the system clock, with a blinking caret overlay.
module hpdl_write_sequencer
  import hpdl_pkg::*;
#(
  parameter int SETUP_CYC  = 4,
  parameter int PULSE_CYC  = 8,
  parameter int HOLD_CYC   = 4,
  parameter int GAP_CYC    = 64,
  parameter int BLINK_BITS = 22
) (
  input  logic       CLK_i,
  input  logic       RST_N_i,
  input  logic       i_enable,
  input  logic       i_caret_en,
  input  logic [3:0] i_caret_pos,
  output logic       o_rd_en,
  output logic [3:0] o_rd_addr,
  input  logic [7:0] i_rd_data,
  output logic [6:0] o_hpdl_d,
  output logic [1:0] o_hpdl_a,
  output logic [3:0] o_hpdl_wr_n,
  output logic       o_frame_done
);

  localparam int PH_MAX = maxOf(maxOf(SETUP_CYC, PULSE_CYC), maxOf(HOLD_CYC, GAP_CYC));
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(SETUP_CYC - 1);
  localparam logic [PH_W-1:0] PULSE_LAST = PH_W'(PULSE_CYC - 1);
  localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(HOLD_CYC - 1);
  localparam logic [PH_W-1:0] GAP_LAST   = PH_W'(GAP_CYC - 1);
  localparam logic [3:0]      LAST_PLACE = 4'(NUM_PLACES - 1);

  state_e                r_state;
  state_e                w_stateNext;
  logic [PH_W-1:0]       r_phase;
  logic [PH_W-1:0]       w_phaseNext;
  logic                  w_phaseLast;
  logic [3:0]            r_place;
  logic [BLINK_BITS-1:0] r_blink;
  logic                  r_rdEn;
  logic [3:0]            r_wrN;
  logic [6:0]            r_d;
  logic [1:0]            r_a;
  logic                  r_frameDone;
  logic                  w_caret;
  logic [6:0]            w_mapped;

  assign w_caret = i_caret_en && (i_caret_pos == r_place) && r_blink[BLINK_BITS-1];

  hpdl_char_map u_charMap (
    .i_char  (i_rd_data),
    .i_caret (w_caret),
    .o_char  (w_mapped)
  );

  // One shared phase counter times every multi-cycle state; it clears on each transition
  // and saturates in GAP so a disabled sequencer can restart immediately.
  always_comb begin
    w_stateNext = r_state;
    w_phaseNext = r_phase;
    w_phaseLast = 1'b1;
    case (r_state)
      ST_GAP:    w_phaseLast = (r_phase == GAP_LAST);
      ST_SETUP:  w_phaseLast = (r_phase == SETUP_LAST);
      ST_STROBE: w_phaseLast = (r_phase == PULSE_LAST);
      ST_HOLD:   w_phaseLast = (r_phase == HOLD_LAST);
      default:   w_phaseLast = 1'b1;
    endcase
    case (r_state)
      ST_GAP:    if (w_phaseLast && i_enable) w_stateNext = ST_FETCH;
      ST_FETCH:  w_stateNext = ST_LATCH;
      ST_LATCH:  w_stateNext = ST_SETUP;
      ST_SETUP:  if (w_phaseLast) w_stateNext = ST_STROBE;
      ST_STROBE: if (w_phaseLast) w_stateNext = ST_HOLD;
      ST_HOLD:   if (w_phaseLast) w_stateNext = (r_place == LAST_PLACE) ? ST_GAP : ST_FETCH;
      default:   w_stateNext = ST_GAP;
    endcase
    if (w_stateNext != r_state) begin
      w_phaseNext = '0;
    end else if (!w_phaseLast) begin
      w_phaseNext = r_phase + 1'b1;
    end
  end

  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      r_state <= ST_GAP;
      r_phase <= '0;
    end else begin
      r_state <= w_stateNext;
      r_phase <= w_phaseNext;
    end
  end

  // Display-facing outputs are registered from the next state so the pins never glitch.
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      r_place     <= 4'd0;
      r_blink     <= '0;
      r_rdEn      <= 1'b0;
      r_wrN       <= 4'b1111;
      r_d         <= 7'd0;
      r_a         <= 2'b11;
      r_frameDone <= 1'b0;
    end else begin
      r_blink     <= r_blink + 1'b1;
      r_rdEn      <= (w_stateNext == ST_FETCH);
      r_wrN       <= (w_stateNext == ST_STROBE) ? ~(4'b0001 << r_place[3:2]) : 4'b1111;
      r_frameDone <= (r_state == ST_HOLD) && w_phaseLast && (r_place == LAST_PLACE);
      if (r_state == ST_LATCH) begin
        r_d <= w_mapped;
        r_a <= ~r_place[1:0];
      end
      if ((r_state == ST_HOLD) && w_phaseLast) begin
        r_place <= r_place + 4'd1;
      end
    end
  end

  assign o_rd_en      = r_rdEn;
  assign o_rd_addr    = r_place;
  assign o_hpdl_d     = r_d;
  assign o_hpdl_a     = r_a;
  assign o_hpdl_wr_n  = r_wrN;
  assign o_frame_done = r_frameDone;

endmodule

// File: tb/tb_hpdl_write_sequencer.sv
// Directed, table-driven bench for hpdl_write_sequencer with a cycle monitor that watches
// write-cycle timing on every frame.
module tb_hpdl_write_sequencer;

  localparam int SETUP_CYC = 4;
  localparam int PULSE_CYC = 8;
  localparam int HOLD_CYC  = 4;
  localparam int GAP_CYC   = 64;
  localparam int FRAME_CYC = 352;

  typedef struct {
    logic [7:0] data;
    logic [3:0] wrN;
    logic [1:0] a;
    logic [6:0] d;
  } vec_t;

  typedef struct {
    logic [3:0] wrN;
    logic [1:0] a;
    logic [6:0] d;
  } wr_t;

  logic       CLK = 1'b0;
  logic       RST_N_i = 1'b1;
  logic       i_enable = 1'b0;
  logic       i_caret_en = 1'b0;
  logic [3:0] i_caret_pos = 4'd0;
  logic [7:0] i_rd_data = 8'd0;
  logic       o_rd_en;
  logic [3:0] o_rd_addr;
  logic [6:0] o_hpdl_d;
  logic [1:0] o_hpdl_a;
  logic [3:0] o_hpdl_wr_n;
  logic       o_frame_done;

  logic [7:0] bufMem [16];
  vec_t       helloVec [16];
  vec_t       mapVec [16];
  wr_t        wrQ [$];
  int         lenQ [$];
  int         doneQ [$];

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         rdCount = 0;
  int         pulseLen = 0;
  int         lastChange = 0;
  int         lastRise = -1000;
  logic [3:0] prevWr = 4'hF;
  logic [8:0] prevDA = 9'h003;
  logic       prevDone = 1'b0;
  logic [3:0] expAddr = 4'd0;
  logic [3:0] tbBlink;

  hpdl_write_sequencer #(.BLINK_BITS(4)) dut (
    .CLK_i        (CLK),
    .RST_N_i      (RST_N_i),
    .i_enable     (i_enable),
    .i_caret_en   (i_caret_en),
    .i_caret_pos  (i_caret_pos),
    .o_rd_en      (o_rd_en),
    .o_rd_addr    (o_rd_addr),
    .i_rd_data    (i_rd_data),
    .o_hpdl_d     (o_hpdl_d),
    .o_hpdl_a     (o_hpdl_a),
    .o_hpdl_wr_n  (o_hpdl_wr_n),
    .o_frame_done (o_frame_done)
  );

  always #5 CLK = ~CLK;

  // Character buffer: data is valid the cycle after the read strobe.
  always @(posedge CLK) begin
    if (o_rd_en) i_rd_data <= bufMem[o_rd_addr];
  end

  // Reference for the free-running 4-bit blink counter.
  always @(posedge CLK or negedge RST_N_i) begin
    if (!RST_N_i) tbBlink <= 4'd0;
    else          tbBlink <= tbBlink + 4'd1;
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write-cycle monitor: captures each write and checks D/A stability and strobe shape.
  always begin
    wr_t w;
    @(posedge CLK);
    #1;
    cyc++;
    if (!RST_N_i) begin
      prevWr     = 4'hF;
      pulseLen   = 0;
      expAddr    = 4'd0;
      prevDone   = 1'b0;
      lastChange = cyc;
      lastRise   = -1000;
      prevDA     = {o_hpdl_d, o_hpdl_a};
    end else begin
      if ({o_hpdl_d, o_hpdl_a} != prevDA) begin
        checkVal("daChangeWhileWrLow", o_hpdl_wr_n, 4'hF);
        checkVal("daChangeInHold", ((cyc - lastRise) >= HOLD_CYC), 1);
        lastChange = cyc;
      end
      if (o_hpdl_wr_n != 4'hF) begin
        checkVal("oneWrLow", $countones(~o_hpdl_wr_n), 1);
        if (prevWr == 4'hF) begin
          checkVal("daSetup", ((cyc - lastChange) >= SETUP_CYC), 1);
          w.wrN = o_hpdl_wr_n;
          w.a   = o_hpdl_a;
          w.d   = o_hpdl_d;
          wrQ.push_back(w);
          pulseLen = 1;
        end else if (o_hpdl_wr_n != prevWr) begin
          pulseLen = PULSE_CYC + 100;
        end else begin
          pulseLen++;
        end
      end else if (prevWr != 4'hF) begin
        checkVal("wrPulseLen", pulseLen, PULSE_CYC);
        lenQ.push_back(pulseLen);
        lastRise = cyc;
      end
      if (o_rd_en) begin
        checkVal("rdAddr", o_rd_addr, expAddr);
        expAddr = expAddr + 4'd1;
        rdCount++;
      end
      if (o_frame_done) begin
        checkVal("doneWidth", prevDone, 0);
        doneQ.push_back(cyc);
      end
      prevDone = o_frame_done;
      prevWr   = o_hpdl_wr_n;
      prevDA   = {o_hpdl_d, o_hpdl_a};
    end
  end

  task automatic waitDone(input int n, input int budget, input string name);
    int start;
    int k;
    start = doneQ.size();
    k = 0;
    while (doneQ.size() < start + n && k < budget) begin
      @(posedge CLK);
      #2;
      k++;
    end
    checkVal({name, "_doneSeen"}, (doneQ.size() >= start + n), 1);
  endtask

  task automatic runOneFrame(input string name);
    int n0;
    int k;
    n0 = rdCount;
    k = 0;
    i_enable = 1'b1;
    while (rdCount == n0 && k < 200) begin
      @(posedge CLK);
      #2;
      k++;
    end
    i_enable = 1'b0;
    checkVal({name, "_started"}, (rdCount != n0), 1);
    waitDone(1, 600, name);
  endtask

  task automatic applyStimulus(input int which);
    for (int i = 0; i < 16; i++) bufMem[i] = (which == 0) ? helloVec[i].data : mapVec[i].data;
  endtask

  initial begin
    int relCyc;
    int k;
    int n0;
    logic [6:0] expD;

    helloVec[0]  = '{8'h48, 4'b1110, 2'b11, 7'h48};
    helloVec[1]  = '{8'h45, 4'b1110, 2'b10, 7'h45};
    helloVec[2]  = '{8'h4C, 4'b1110, 2'b01, 7'h4C};
    helloVec[3]  = '{8'h4C, 4'b1110, 2'b00, 7'h4C};
    helloVec[4]  = '{8'h4F, 4'b1101, 2'b11, 7'h4F};
    helloVec[5]  = '{8'h20, 4'b1101, 2'b10, 7'h20};
    helloVec[6]  = '{8'h57, 4'b1101, 2'b01, 7'h57};
    helloVec[7]  = '{8'h4F, 4'b1101, 2'b00, 7'h4F};
    helloVec[8]  = '{8'h52, 4'b1011, 2'b11, 7'h52};
    helloVec[9]  = '{8'h4C, 4'b1011, 2'b10, 7'h4C};
    helloVec[10] = '{8'h44, 4'b1011, 2'b01, 7'h44};
    helloVec[11] = '{8'h20, 4'b1011, 2'b00, 7'h20};
    helloVec[12] = '{8'h31, 4'b0111, 2'b11, 7'h31};
    helloVec[13] = '{8'h32, 4'b0111, 2'b10, 7'h32};
    helloVec[14] = '{8'h33, 4'b0111, 2'b01, 7'h33};
    helloVec[15] = '{8'h34, 4'b0111, 2'b00, 7'h34};

    mapVec[0]  = '{8'h00, 4'b1110, 2'b11, 7'h20};
    mapVec[1]  = '{8'h1F, 4'b1110, 2'b10, 7'h20};
    mapVec[2]  = '{8'h20, 4'b1110, 2'b01, 7'h20};
    mapVec[3]  = '{8'h5F, 4'b1110, 2'b00, 7'h5F};
    mapVec[4]  = '{8'h60, 4'b1101, 2'b11, 7'h40};
    mapVec[5]  = '{8'h7F, 4'b1101, 2'b10, 7'h5F};
    mapVec[6]  = '{8'h80, 4'b1101, 2'b01, 7'h20};
    mapVec[7]  = '{8'hFF, 4'b1101, 2'b00, 7'h20};
    mapVec[8]  = '{8'h61, 4'b1011, 2'b11, 7'h41};
    mapVec[9]  = '{8'h7A, 4'b1011, 2'b10, 7'h5A};
    mapVec[10] = '{8'h0D, 4'b1011, 2'b01, 7'h20};
    mapVec[11] = '{8'hC1, 4'b1011, 2'b00, 7'h20};
    mapVec[12] = '{8'h41, 4'b0111, 2'b11, 7'h41};
    mapVec[13] = '{8'h7B, 4'b0111, 2'b10, 7'h5B};
    mapVec[14] = '{8'h3F, 4'b0111, 2'b01, 7'h3F};
    mapVec[15] = '{8'h9F, 4'b0111, 2'b00, 7'h20};

    $display("[TB] reset values");
    applyStimulus(0);
    #1 RST_N_i = 1'b0;
    #1;
    checkVal("rst_wrN", o_hpdl_wr_n, 4'b1111);
    checkVal("rst_d", o_hpdl_d, 7'h00);
    checkVal("rst_a", o_hpdl_a, 2'b11);
    checkVal("rst_rdEn", o_rd_en, 1'b0);
    checkVal("rst_rdAddr", o_rd_addr, 4'd0);
    checkVal("rst_done", o_frame_done, 1'b0);

    $display("[TB] test 1: HELLO WORLD 1234, two continuous frames");
    i_enable = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N_i = 1'b1;
    relCyc = cyc;
    wrQ.delete();
    waitDone(2, 1200, "t1");
    i_enable = 1'b0;
    checkVal("t1_writes", wrQ.size(), 32);
    for (int i = 0; i < 32 && i < wrQ.size(); i++) begin
      checkVal($sformatf("t1_wrN[%0d]", i), wrQ[i].wrN, helloVec[i % 16].wrN);
      checkVal($sformatf("t1_a[%0d]", i), wrQ[i].a, helloVec[i % 16].a);
      checkVal($sformatf("t1_d[%0d]", i), wrQ[i].d, helloVec[i % 16].d);
    end
    if (doneQ.size() >= 2) begin
      checkVal("t1_firstDoneCyc", doneQ[0] - relCyc, FRAME_CYC);
      checkVal("t1_framePeriod", doneQ[1] - doneQ[0], FRAME_CYC);
    end

    $display("[TB] test 2: character map");
    applyStimulus(1);
    wrQ.delete();
    runOneFrame("t2");
    checkVal("t2_writes", wrQ.size(), 16);
    for (int i = 0; i < 16 && i < wrQ.size(); i++) begin
      checkVal($sformatf("t2_wrN[%0d]", i), wrQ[i].wrN, mapVec[i].wrN);
      checkVal($sformatf("t2_a[%0d]", i), wrQ[i].a, mapVec[i].a);
      checkVal($sformatf("t2_d[%0d]", i), wrQ[i].d, mapVec[i].d);
    end

    $display("[TB] test 3: blinking caret at place 7");
    applyStimulus(0);
    i_caret_en  = 1'b1;
    i_caret_pos = 4'd7;
    for (int f = 0; f < 4; f++) begin
      repeat (70) @(posedge CLK);
      #2;
      // Starting when the blink count reads 0 lands place 7's latch in the dark half;
      // starting at 8 lands it in the lit half.
      k = 0;
      while (tbBlink != ((f % 2 == 1) ? 4'd8 : 4'd0) && k < 40) begin
        @(posedge CLK);
        #2;
        k++;
      end
      wrQ.delete();
      runOneFrame($sformatf("t3_f%0d", f));
      checkVal($sformatf("t3_f%0d_writes", f), wrQ.size(), 16);
      for (int i = 0; i < 16 && i < wrQ.size(); i++) begin
        expD = (i == 7 && f % 2 == 1) ? 7'h5F : helloVec[i].d;
        checkVal($sformatf("t3_f%0d_d[%0d]", f, i), wrQ[i].d, expD);
      end
    end
    i_caret_en = 1'b0;

    $display("[TB] test 4: enable dropped during place 9 strobe");
    wrQ.delete();
    lenQ.delete();
    i_enable = 1'b1;
    k = 0;
    while (!(o_hpdl_wr_n == 4'b1011 && o_hpdl_a == 2'b10) && k < 1000) begin
      @(posedge CLK);
      #2;
      k++;
    end
    checkVal("t4_place9Strobe", (k < 1000), 1);
    i_enable = 1'b0;
    waitDone(1, 600, "t4");
    checkVal("t4_writes", wrQ.size(), 16);
    if (lenQ.size() > 9) checkVal("t4_place9Len", lenQ[9], PULSE_CYC);
    for (int i = 10; i < 16 && i < wrQ.size(); i++) begin
      checkVal($sformatf("t4_wrN[%0d]", i), wrQ[i].wrN, helloVec[i].wrN);
      checkVal($sformatf("t4_d[%0d]", i), wrQ[i].d, helloVec[i].d);
    end
    n0 = rdCount;
    repeat (200) @(posedge CLK);
    #2;
    checkVal("t4_noFetchAfter", rdCount, n0);

    $display("[TB] test 5: reset in mid-strobe");
    i_enable = 1'b1;
    k = 0;
    while (o_hpdl_wr_n == 4'hF && k < 600) begin
      @(posedge CLK);
      #2;
      k++;
    end
    checkVal("t5_strobeSeen", (o_hpdl_wr_n != 4'hF), 1);
    repeat (3) @(posedge CLK);
    #3 RST_N_i = 1'b0;
    #1;
    checkVal("t5_wrN", o_hpdl_wr_n, 4'b1111);
    checkVal("t5_d", o_hpdl_d, 7'h00);
    checkVal("t5_a", o_hpdl_a, 2'b11);
    checkVal("t5_rdEn", o_rd_en, 1'b0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N_i = 1'b1;
    // The release cycle counts as the first, so FETCH appears on the GAP_CYC-th edge after it.
    k = 0;
    while (!o_rd_en && k < 200) begin
      @(posedge CLK);
      #2;
      k++;
    end
    checkVal("t5_fetchEdges", k, GAP_CYC);
    checkVal("t5_fetchAddr", o_rd_addr, 4'd0);
    i_enable = 1'b0;
    waitDone(1, 600, "t5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
